// File: rtl/train_pkg.sv
// Shared FSM state type, default point count and 50 MHz coil timing constants
// for the point throw sequencer.
package train_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRE  = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } seq_state_e;

  localparam int N_POINTS_DEFAULT  = 12;
  localparam int PULSE_100MS       = 5_000_000;
  localparam int GAP_50MS          = 2_500_000;
  localparam int MAX_RETRY_DEFAULT = 2;

  // One shared down-counter serves both FIRE and GAP, so size it for the longer one.
  function automatic int cnt_width(input int pulse_cycles, input int gap_cycles);
    return $clog2(((pulse_cycles > gap_cycles) ? pulse_cycles : gap_cycles) + 1);
  endfunction

endpackage

// File: rtl/point_throw_sequencer_if.sv
// Bus between the interlocking/GPIO side and the point throw sequencer.
// detect/fault are present only when POINT_DETECT_EN is defined.
interface point_throw_sequencer_if #(
  parameter int N = train_pkg::N_POINTS_DEFAULT
);
  logic [N-1:0] route_req;
  logic [N-1:0] invert;
  logic [N-1:0] coil_normal;
  logic [N-1:0] coil_reverse;
  logic [N-1:0] pos_state;
  logic [N-1:0] pending;
  logic         busy;

`ifdef POINT_DETECT_EN
  logic [N-1:0] detect;
  logic [N-1:0] fault;

  modport master (
    output route_req, invert, detect,
    input  coil_normal, coil_reverse, pos_state, pending, busy, fault
  );

  modport slave (
    input  route_req, invert, detect,
    output coil_normal, coil_reverse, pos_state, pending, busy, fault
  );
`else
  modport master (
    output route_req, invert,
    input  coil_normal, coil_reverse, pos_state, pending, busy
  );

  modport slave (
    input  route_req, invert,
    output coil_normal, coil_reverse, pos_state, pending, busy
  );
`endif

endinterface

// File: rtl/point_rr_arbiter.sv
// Combinational round-robin pick: first set bit of pending at or after rr_ptr,
// wrapping from N-1 back to 0.
module point_rr_arbiter #(
  parameter int N     = 12,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     pending_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);
  localparam int SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] cand_idx [N];
  logic [N-1:0]     cand_hit;

  // Candidate gi is the point gi places after rr_ptr, modulo N.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [SUM_W-1:0] sum;
    assign sum          = {1'b0, rr_ptr_i} + SUM_W'(gi);
    assign cand_idx[gi] = (sum >= SUM_W'(N)) ? IDX_W'(sum - SUM_W'(N)) : IDX_W'(sum);
    assign cand_hit[gi] = pending_i[cand_idx[gi]];
  end

  always_comb begin
    grant_idx_o = '0;
    any_o       = |cand_hit;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        grant_idx_o = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/point_throw_sequencer.sv
// Serves per-point reverse requests round-robin, one coil pulse at a time with a recovery gap.
// Optional position check and retry/fault handling is enabled by defining POINT_DETECT_EN.
module point_throw_sequencer
  import train_pkg::*;
#(
  parameter int N_POINTS     = N_POINTS_DEFAULT,
  parameter int PULSE_CYCLES = PULSE_100MS,
  parameter int GAP_CYCLES   = GAP_50MS
`ifdef POINT_DETECT_EN
 ,parameter int MAX_RETRY    = MAX_RETRY_DEFAULT
`endif
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  point_throw_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(N_POINTS);
  localparam int CNT_W = cnt_width(PULSE_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_POINTS - 1);

  seq_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                tgt_q, tgt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_POINTS-1:0] pos_state_q, pos_state_d;
  logic [N_POINTS-1:0] init_mask_q, init_mask_d;

  logic [N_POINTS-1:0] target;
  logic [N_POINTS-1:0] pending;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    idx_next;
  logic                any_pending;
  logic [N_POINTS-1:0] coil_normal;
  logic [N_POINTS-1:0] coil_reverse;
  logic                busy;

`ifdef POINT_DETECT_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [N_POINTS-1:0] fault_q, fault_d;
`endif

  // A point stays pending until its commanded position matches the polarity-trimmed request.
  assign target   = bus.route_req ^ bus.invert;
  assign pending  = init_mask_q | (target ^ pos_state_q);
  assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

  point_rr_arbiter #(
    .N     (N_POINTS),
    .IDX_W (IDX_W)
  ) u_arb (
    .pending_i   (pending),
    .rr_ptr_i    (rr_ptr_q),
    .grant_idx_o (grant_idx),
    .any_o       (any_pending)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rr_ptr_q    <= '0;
      tgt_q       <= 1'b0;
      cnt_q       <= '0;
      pos_state_q <= '0;
      init_mask_q <= '1;
`ifdef POINT_DETECT_EN
      retry_q     <= '0;
      fault_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
      tgt_q       <= tgt_d;
      cnt_q       <= cnt_d;
      pos_state_q <= pos_state_d;
      init_mask_q <= init_mask_d;
`ifdef POINT_DETECT_EN
      retry_q     <= retry_d;
      fault_q     <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    tgt_d       = tgt_q;
    cnt_d       = cnt_q;
    pos_state_d = pos_state_q;
    init_mask_d = init_mask_q;
`ifdef POINT_DETECT_EN
    retry_d     = retry_q;
    fault_d     = fault_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_pending) begin
          idx_d   = grant_idx;
          tgt_d   = target[grant_idx];
          cnt_d   = PULSE_LOAD;
          state_d = FIRE;
        end
      end
      FIRE: begin
        // The latched direction is committed even if the request moved meanwhile;
        // any mismatch simply re-raises pending for a later turn.
        if (cnt_q == CNT_W'(1)) begin
          pos_state_d[idx_q] = tgt_q;
          init_mask_d[idx_q] = 1'b0;
          cnt_d              = GAP_LOAD;
          state_d            = GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(1)) begin
`ifdef POINT_DETECT_EN
          state_d  = CHECK;
`else
          rr_ptr_d = idx_next;
          state_d  = IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CHECK: begin
`ifdef POINT_DETECT_EN
        if (bus.detect[idx_q] == tgt_q) begin
          retry_d        = '0;
          fault_d[idx_q] = 1'b0;
          rr_ptr_d       = idx_next;
          state_d        = IDLE;
        end else if (retry_q < RETRY_LIMIT) begin
          // Re-throw the same point without advancing the round-robin pointer.
          retry_d = retry_q + 1'b1;
          cnt_d   = PULSE_LOAD;
          state_d = FIRE;
        end else begin
          retry_d        = '0;
          fault_d[idx_q] = 1'b1;
          rr_ptr_d       = idx_next;
          state_d        = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the selected point's coil is driven, and only while in FIRE.
  always_comb begin
    coil_normal  = '0;
    coil_reverse = '0;
    busy         = (state_q != IDLE);
    if (state_q == FIRE) begin
      coil_reverse[idx_q] = tgt_q;
      coil_normal[idx_q]  = ~tgt_q;
    end
  end

  assign bus.coil_normal  = coil_normal;
  assign bus.coil_reverse = coil_reverse;
  assign bus.pos_state    = pos_state_q;
  assign bus.pending      = pending;
  assign bus.busy         = busy;
`ifdef POINT_DETECT_EN
  assign bus.fault        = fault_q;
`endif

endmodule

// File: tb/tb_point_throw_sequencer.sv
// Directed bench for point_throw_sequencer with short timing (pulse 4, gap 3).
// Covers the POINT_DETECT_EN retry/fault path when that macro is defined.
module tb_point_throw_sequencer;

  localparam int N = 12;
`ifdef POINT_DETECT_EN
  localparam int EXP_GAP = 5;
`else
  localparam int EXP_GAP = 4;
`endif

  typedef struct {
    int idx;
    bit rev;
    int len;
    int gap;
  } pulse_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  point_throw_sequencer_if #(.N(N)) bus ();

  point_throw_sequencer #(
    .N_POINTS     (N),
    .PULSE_CYCLES (4),
    .GAP_CYCLES   (3)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus.slave)
  );

`ifdef POINT_DETECT_EN
  // Simple point machine: follows whichever coil is energised, unless stuck.
  logic [N-1:0] det_model = '0;
  logic [N-1:0] stuck;
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (bus.coil_reverse[i] === 1'b1) det_model[i] <= 1'b1;
      else if (bus.coil_normal[i] === 1'b1) det_model[i] <= 1'b0;
    end
  end
  assign bus.detect = det_model & ~stuck;
`endif

  // Pulse monitor: records each coil pulse (point, direction, length, idle cycles before it).
  pulse_t      pulses[$];
  int          cyc_cnt   = 0;
  int          run_len   = 0;
  int          run_start = 0;
  int          last_end  = 0;
  int          inv_viol  = 0;
  logic [23:0] run_vec   = '0;

  always @(negedge clk) begin
    logic [23:0] cur;
    pulse_t      p;
    cyc_cnt++;
    cur = {bus.coil_reverse, bus.coil_normal};
    if ($countones(cur) > 1) inv_viol++;
    if (cur != '0) begin
      if (run_len == 0) begin
        run_vec   = cur;
        run_start = cyc_cnt;
      end else if (cur != run_vec) begin
        inv_viol++;
      end
      run_len++;
    end else if (run_len != 0) begin
      p.idx = -1;
      for (int i = 0; i < 24; i++) if (run_vec[i]) p.idx = i % 12;
      p.rev    = |run_vec[23:12];
      p.len    = run_len;
      p.gap    = run_start - last_end - 1;
      last_end = run_start + run_len - 1;
      pulses.push_back(p);
      run_len = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pulse(input string tag, input int k, input int idx, input bit rev, input int gap);
    check({tag, "_present"}, 32'(pulses.size() > k), 32'd1);
    if (pulses.size() > k) begin
      check({tag, "_idx"}, pulses[k].idx, idx);
      check({tag, "_dir"}, 32'(pulses[k].rev), 32'(rev));
      check({tag, "_len"}, pulses[k].len, 4);
      if (gap >= 0) check({tag, "_gap"}, pulses[k].gap, gap);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus.busy === 1'b0 && bus.pending === '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_settle"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.route_req = '0;
    bus.invert    = '0;
`ifdef POINT_DETECT_EN
    stuck         = '0;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_coil_n", bus.coil_normal, 12'h000);
    check("rst_coil_r", bus.coil_reverse, 12'h000);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_pos", bus.pos_state, 12'h000);
    check("rst_pending", bus.pending, 12'hFFF);
`ifdef POINT_DETECT_EN
    check("rst_fault", bus.fault, 12'h000);
`endif

    // 1: initial sweep, every point thrown normal in order 0..11
    pulses.delete();
    reset = 1'b0;
    wait_idle("t1", 300);
    check("t1_count", pulses.size(), 12);
    for (int i = 0; i < N; i++) begin
      check_pulse($sformatf("t1_p%0d", i), i, i, 1'b0, (i == 0) ? -1 : EXP_GAP);
    end
    check("t1_pos", bus.pos_state, 12'h000);
    $display("[TB] t1 sweep: %0d pulses", pulses.size());

    // 2: reverse points 0 and 1
    @(negedge clk);
    pulses.delete();
    bus.route_req = 12'h003;
    wait_idle("t2", 100);
    check("t2_count", pulses.size(), 2);
    check_pulse("t2_p0", 0, 0, 1'b1, -1);
    check_pulse("t2_p1", 1, 1, 1'b1, EXP_GAP);
    check("t2_pos", bus.pos_state, 12'h003);
    $display("[TB] t2 reverse 0,1: pos_state=%03h", bus.pos_state);

    // 3a: invert trim on point 5
    @(negedge clk);
    pulses.delete();
    bus.invert = 12'h020;
    #1;
    check("t3_pending", bus.pending, 12'h020);
    wait_idle("t3a", 100);
    check("t3a_count", pulses.size(), 1);
    check_pulse("t3a_p0", 0, 5, 1'b1, -1);
    check("t3a_pos", bus.pos_state, 12'h023);
    $display("[TB] t3a invert 5: pos_state=%03h", bus.pos_state);

    // 3b: point 5 request withdrawn and restored while point 8 is being thrown
    @(negedge clk);
    pulses.delete();
    bus.route_req = 12'h103;
    bus.invert    = 12'h000;
    #1;
    check("t3b_pending", bus.pending, 12'h120);
    @(negedge clk);
    check("t3b_coil_r", bus.coil_reverse, 12'h100);
    check("t3b_coil_n", bus.coil_normal, 12'h000);
    bus.invert = 12'h020;
    #1;
    check("t3b_pending2", bus.pending, 12'h100);
    wait_idle("t3b", 100);
    check("t3b_count", pulses.size(), 1);
    check_pulse("t3b_p0", 0, 8, 1'b1, -1);
    check("t3b_pos", bus.pos_state, 12'h123);
    $display("[TB] t3b toggle-back: %0d pulses", pulses.size());

    // 4: point 2 request flips during its own FIRE
    @(negedge clk);
    pulses.delete();
    bus.route_req = 12'h117;
    #1;
    check("t4_pending", bus.pending, 12'h014);
    @(negedge clk);
    check("t4_coil_r", bus.coil_reverse, 12'h004);
    bus.route_req = 12'h113;
    #1;
    check("t4_pending2", bus.pending, 12'h010);
    wait_idle("t4", 200);
    check("t4_count", pulses.size(), 3);
    check_pulse("t4_p0", 0, 2, 1'b1, -1);
    check_pulse("t4_p1", 1, 4, 1'b1, EXP_GAP);
    check_pulse("t4_p2", 2, 2, 1'b0, EXP_GAP);
    check("t4_pos", bus.pos_state, 12'h133);
    $display("[TB] t4 mid-fire change: %0d pulses", pulses.size());

    // 5: reset in the second FIRE cycle of point 3
    @(negedge clk);
    pulses.delete();
    bus.route_req = 12'h11B;
    @(negedge clk);
    check("t5_fire1", bus.coil_reverse, 12'h008);
    @(negedge clk);
    check("t5_fire2", bus.coil_reverse, 12'h008);
    reset = 1'b1;
    @(negedge clk);
    check("t5_coil_r", bus.coil_reverse, 12'h000);
    check("t5_coil_n", bus.coil_normal, 12'h000);
    check("t5_busy", bus.busy, 1'b0);
    check("t5_pos", bus.pos_state, 12'h000);
    check("t5_pending", bus.pending, 12'hFFF);
    @(negedge clk);
    check("t5_trunc_count", pulses.size(), 1);
    if (pulses.size() > 0) begin
      check("t5_trunc_idx", pulses[$].idx, 3);
      check("t5_trunc_len", pulses[$].len, 2);
    end
    bus.route_req = '0;
    bus.invert    = '0;
    pulses.delete();
    reset = 1'b0;
    wait_idle("t5", 300);
    check("t5_count", pulses.size(), 12);
    check_pulse("t5_p0", 0, 0, 1'b0, -1);
    check_pulse("t5_p11", 11, 11, 1'b0, EXP_GAP);
    check("t5_pos_end", bus.pos_state, 12'h000);
    $display("[TB] t5 reset mid-pulse: %0d pulses after release", pulses.size());

`ifdef POINT_DETECT_EN
    // 6: detector stuck at normal on point 7 -> retries then fault
    @(negedge clk);
    pulses.delete();
    stuck         = 12'h080;
    bus.route_req = 12'h080;
    wait_idle("t6", 200);
    check("t6_count", pulses.size(), 3);
    check_pulse("t6_p0", 0, 7, 1'b1, -1);
    check_pulse("t6_p1", 1, 7, 1'b1, 4);
    check_pulse("t6_p2", 2, 7, 1'b1, 4);
    check("t6_fault", bus.fault, 12'h080);
    check("t6_busy", bus.busy, 1'b0);
    check("t6_pos", bus.pos_state, 12'h080);
    stuck = '0;
    repeat (5) @(negedge clk);
    check("t6_fault_sticky", bus.fault, 12'h080);
    $display("[TB] t6 detect fault: fault=%03h", bus.fault);
`endif

    check("invariants", inv_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

endmodule
